// File: rtl/jtag_wb_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : jtag_wb_mailbox
// Purpose  : Wishbone-slave mailbox between a JTAG Wishbone master (host)
//            and on-chip logic (core). Two FIFOs connect them:
//              RX : host -> core, filled by Wishbone writes to word 0,
//                   drained by the rx_* valid/ready stream.
//              TX : core -> host, filled by the tx_* valid/ready stream,
//                   drained by Wishbone reads of word 0.
//            Word 1 is a status/control register:
//              read : bit0 TX not empty, bit1 RX full, bit2 RX overflow,
//                     [15:8] TX count, [23:16] RX count, others 0
//              write: bit2 = 1 clears the RX overflow flag
// Ports    : clk, reset        - single clock, synchronous active-high reset
//            s_*_i / s_*_o     - Wishbone classic slave (only s_addr_i[0]
//                                decoded; s_sel_i and s_cti_i ignored)
//            rx_dat_o/rx_valid_o/rx_ready_i - host-to-core stream
//            tx_dat_i/tx_valid_i/tx_ready_o - core-to-host stream
// Revision : 1.0 - initial release
// ============================================================================
module jtag_wb_mailbox #(
  parameter int Dw    = 32,
  parameter int Aw    = 32,
  parameter int SELw  = 4,
  parameter int TAGw  = 3,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  // Wishbone slave
  input  logic [Dw-1:0]   s_dat_i,
  input  logic [Aw-1:0]   s_addr_i,
  input  logic [SELw-1:0] s_sel_i,
  input  logic [TAGw-1:0] s_cti_i,
  input  logic            s_stb_i,
  input  logic            s_cyc_i,
  input  logic            s_we_i,
  output logic [Dw-1:0]   s_dat_o,
  output logic            s_ack_o,
  // host-to-core stream
  output logic [Dw-1:0]   rx_dat_o,
  output logic            rx_valid_o,
  input  logic            rx_ready_i,
  // core-to-host stream
  input  logic [Dw-1:0]   tx_dat_i,
  input  logic            tx_valid_i,
  output logic            tx_ready_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Registered state
  logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CW-1:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic          ovf_q, ovf_d;
  logic          ack_q, ack_d;
  logic [Dw-1:0] dat_q, dat_d;

  // FIFO storage (not reset; pointers/counts define validity)
  logic [Dw-1:0] rx_mem_q [DEPTH];
  logic [Dw-1:0] tx_mem_q [DEPTH];

  // Request decode and FIFO events
  logic          accept;
  logic          rx_full, tx_full, rx_empty, tx_empty;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic [31:0]   status_w;

  // Ignored request fields are folded here so they are visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{s_sel_i, s_cti_i, s_addr_i[Aw-1:1]};

  assign rx_full  = (rx_count_q == FULL_COUNT);
  assign tx_full  = (tx_count_q == FULL_COUNT);
  assign rx_empty = (rx_count_q == '0);
  assign tx_empty = (tx_count_q == '0);

  // The ~s_ack_o term makes a held strobe accept only every second cycle.
  assign accept = s_stb_i & s_cyc_i & ~ack_q;

  // Reset gates every FIFO event so nothing coincident with reset survives.
  assign rx_push = accept & s_we_i & ~s_addr_i[0] & ~rx_full & ~reset;
  assign tx_pop  = accept & ~s_we_i & ~s_addr_i[0] & ~tx_empty & ~reset;
  assign rx_pop  = rx_valid_o & rx_ready_i & ~reset;
  assign tx_push = tx_valid_i & tx_ready_o;

  assign status_w = {8'h00, 8'(rx_count_q), 8'(tx_count_q),
                     5'b0, ovf_q, rx_full, ~tx_empty};

  always_comb begin
    rx_wptr_d  = rx_wptr_q + (rx_push ? PW'(1) : PW'(0));
    rx_rptr_d  = rx_rptr_q + (rx_pop  ? PW'(1) : PW'(0));
    tx_wptr_d  = tx_wptr_q + (tx_push ? PW'(1) : PW'(0));
    tx_rptr_d  = tx_rptr_q + (tx_pop  ? PW'(1) : PW'(0));
    // Guards on push/pop keep counts within 0..DEPTH without saturation.
    rx_count_d = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_pop);

    ovf_d = ovf_q;
    if (accept && s_we_i && !s_addr_i[0] && rx_full) begin
      ovf_d = 1'b1;
    end else if (accept && s_we_i && s_addr_i[0] && s_dat_i[2]) begin
      ovf_d = 1'b0;
    end

    ack_d = accept;

    // Read data is captured on the accept edge and held until the next one.
    dat_d = dat_q;
    if (accept) begin
      if (s_we_i) begin
        dat_d = '0;
      end else if (s_addr_i[0]) begin
        dat_d = Dw'(status_w);
      end else if (!tx_empty) begin
        dat_d = tx_mem_q[tx_rptr_q];
      end else begin
        dat_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_count_q <= '0;
      tx_count_q <= '0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  // Storage writes only; a same-edge pop of the written slot is impossible
  // because a pop requires a non-zero count beforehand.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wptr_q] <= s_dat_i;
    end
    if (tx_push) begin
      tx_mem_q[tx_wptr_q] <= tx_dat_i;
    end
  end

  assign s_ack_o    = ack_q;
  assign s_dat_o    = dat_q;
  assign rx_valid_o = ~rx_empty;
  assign rx_dat_o   = rx_mem_q[rx_rptr_q];
  assign tx_ready_o = ~tx_full & ~reset;

endmodule
`default_nettype wire

// File: doc/jtag_wb_mailbox.md
JTAG_WB_MAILBOX -- requirements
Module: jtag_wb_mailbox

Interface
REQ-001 Parameter Dw, default 32: Wishbone and stream data width.
REQ-002 Parameter Aw, default 32: Wishbone word-address width; only s_addr_i[0] is decoded.
REQ-003 Parameter SELw, default 4: byte-select width; s_sel_i is ignored, full words only.
REQ-004 Parameter TAGw, default 3: cycle-type tag width; s_cti_i is ignored, classic single cycles only.
REQ-005 Parameter DEPTH, default 8: entries per FIFO; must be a power of two, 2..128.
REQ-006 Port clk, input, 1: the single clock.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Ports s_dat_i [Dw], s_addr_i [Aw], s_sel_i [SELw], s_cti_i [TAGw], s_stb_i, s_cyc_i, s_we_i, all inputs: Wishbone slave request, driven by the JTAG Wishbone master.
REQ-009 Ports s_dat_o [Dw] and s_ack_o [1], outputs: Wishbone read data and acknowledge.
REQ-010 Ports rx_dat_o [Dw] and rx_valid_o [1], outputs, and rx_ready_i [1], input: host-to-core stream.
REQ-011 Ports tx_dat_i [Dw] and tx_valid_i [1], inputs, and tx_ready_o [1], output: core-to-host stream.

Function
REQ-012 Request accept: a request is accepted on a rising edge where s_stb_i & s_cyc_i & ~s_ack_o.
REQ-013 On accept, s_ack_o shall be registered high for exactly one cycle; latency from request to ack is 1 cycle.
REQ-014 Because of the ~s_ack_o term, back-to-back requests are acked every second cycle.
REQ-015 s_dat_o is registered on the accept edge, shall hold its value until the next accept, and is 0 for writes.
REQ-016 Write, addr[0]=0: push s_dat_i into the RX FIFO if rx_count<DEPTH.
REQ-017 Write to a full RX FIFO: the data is dropped, the overflow flag sets, and the cycle is still acked.
REQ-018 Read, addr[0]=0: if tx_count>0, return the TX FIFO head and pop it; otherwise return 0 with no pop.
REQ-019 Read, addr[0]=1, status word: bit0=(tx_count!=0), bit1=(rx_count==DEPTH), bit2=overflow, [15:8]=tx_count, [23:16]=rx_count, all other bits 0.
REQ-020 Write, addr[0]=1: s_dat_i[2]=1 clears overflow; all other bits are ignored.
REQ-021 Overflow set and clear in the same cycle is impossible (single request port).
REQ-022 RX stream: rx_valid_o=(rx_count!=0) and rx_dat_o=RX head, combinational from FIFO state.
REQ-023 RX pop occurs when rx_valid_o & rx_ready_i.
REQ-024 TX stream: tx_ready_o=(tx_count<DEPTH) & ~reset.
REQ-025 TX push occurs when tx_valid_i & tx_ready_o.
REQ-026 Simultaneous push and pop on the same FIFO: both execute and the count is unchanged.
REQ-027 Push on a full FIFO is refused even if a same-cycle pop exists.
REQ-028 Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 Counts are log2(DEPTH)+1 bits and saturate neither up nor down, because the guards prevent it.
REQ-030 Status count fields are zero-extended to 8 bits.
REQ-031 FIFO storage is registered with no read-before-write hazard; a pop of the entry written on the same edge cannot occur, since count must be >0.

Reset
REQ-032 On reset: pointers, counts, overflow, s_ack_o and s_dat_o are 0; rx_valid_o=0 and tx_ready_o=0.
REQ-033 FIFO storage contents need not be reset; rx_dat_o is don't-care while rx_valid_o=0.
REQ-034 Reset mid-transaction: s_ack_o drops on the reset edge, and a request still asserted after reset is accepted afresh.
REQ-035 Any push or pop coincident with reset is discarded.

Verification
REQ-036 Host write: write 0x11223344 to addr 0 with rx_ready_i=0 -> ack 1 cycle later, rx_valid_o=1, rx_dat_o=0x11223344; status read = 0x00010000.
REQ-037 Core-to-host read: push 0xA5 and 0x5A on the TX stream, then read addr 0 twice -> 0xA5 then 0x5A; a third read returns 0 with status bit0=0.
REQ-038 RX overflow: with DEPTH=8 and rx_ready_i=0, write 9 words -> 9 acks; status = 0x00080006 (rx_count=8, full, overflow).
REQ-039 Overflow clear: then write 0x4 to addr 1 -> status = 0x00080002; rx drains exactly the first 8 words in order.
REQ-040 Concurrency: TX full, then a Wishbone pop concurrent with a tx_valid_i push -> tx_ready_o was 0, so no push occurs and tx_count=7; on the next push tx_count=8.
REQ-041 Held strobe: hold s_stb_i/s_cyc_i for 6 cycles on a read of addr 0 -> exactly 3 acks and 3 pops.
REQ-042 Reset mid-operation: assert reset while ack is high with 3 RX entries -> next cycle s_ack_o=0, rx_valid_o=0, status=0.
